// File: rtl/pipelined_parallel_adder.sv
// WIDTH-bit add/subtract with the carry chain cut into WIDTH/STAGE_W registered chunks.
// Define PIPELINED_ADDER_SIGNED_OVF_EN to add the registered signed-overflow output ovf.
module ppa_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

module pipelined_parallel_adder #(
  parameter int WIDTH   = 8,
  parameter int STAGE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef PIPELINED_ADDER_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int NSTAGES = WIDTH / STAGE_W;

  if ((WIDTH % STAGE_W) != 0 || NSTAGES < 1 || NSTAGES > 16) begin : g_cfg_chk
    $error("pipelined_parallel_adder: WIDTH must be a multiple of STAGE_W with 1..16 stages");
  end

  logic             advance;
  logic             take;
  logic [WIDTH-1:0] bx;
  logic             c0;
  logic [NSTAGES-1:0] vld_pipe_d, vld_pipe_q;

  // Whole pipe moves as one; a bubble at the output never blocks the pipe.
  assign advance  = out_ready | ~out_valid;
  assign in_ready = advance;
  assign take     = in_valid & advance;
  assign bx       = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe_q <= '0;
    else        vld_pipe_q <= vld_pipe_d;
  end

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stg
    localparam int LO = k * STAGE_W;
    localparam int HI = LO + STAGE_W;

    logic [STAGE_W-1:0] ca, cb, cs;
    logic               ci, co, vin, ld;
    logic               c_d, c_q;
    logic [HI-1:0]      psum_nx, psum_d, psum_q;

    if (k == 0) begin : g_src
      assign ca      = a[STAGE_W-1:0];
      assign cb      = bx[STAGE_W-1:0];
      assign ci      = c0;
      assign vin     = take;
      assign psum_nx = cs;
    end else begin : g_src
      assign ca      = g_stg[k-1].g_op.opa_q[STAGE_W-1:0];
      assign cb      = g_stg[k-1].g_op.opb_q[STAGE_W-1:0];
      assign ci      = g_stg[k-1].c_q;
      assign vin     = vld_pipe_q[k-1];
      assign psum_nx = {cs, g_stg[k-1].psum_q};
    end

    ppa_chunk #(.W(STAGE_W)) u_chunk (
      .a  (ca),
      .b  (cb),
      .ci (ci),
      .s  (cs),
      .co (co)
    );

    // Data only moves with a valid op; bubble stages keep stale, unobservable contents.
    assign ld            = advance & vin;
    assign vld_pipe_d[k] = advance ? vin : vld_pipe_q[k];

    always_comb begin
      c_d    = c_q;
      psum_d = psum_q;
      if (ld) begin
        c_d    = co;
        psum_d = psum_nx;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_q    <= 1'b0;
        psum_q <= '0;
      end else begin
        c_q    <= c_d;
        psum_q <= psum_d;
      end
    end

    // Operand bits not yet consumed ride along, shifted so the next chunk sits at bit 0.
    if (k < NSTAGES - 1) begin : g_op
      localparam int RW = WIDTH - HI;
      logic [RW-1:0] ra, rb;
      logic [RW-1:0] opa_d, opa_q, opb_d, opb_q;

      if (k == 0) begin : g_rem
        assign ra = a[WIDTH-1:HI];
        assign rb = bx[WIDTH-1:HI];
      end else begin : g_rem
        assign ra = g_stg[k-1].g_op.opa_q[WIDTH-LO-1:STAGE_W];
        assign rb = g_stg[k-1].g_op.opb_q[WIDTH-LO-1:STAGE_W];
      end

      always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        if (ld) begin
          opa_d = ra;
          opb_d = rb;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end
  end

  assign out_valid = vld_pipe_q[NSTAGES-1];
  assign sum       = g_stg[NSTAGES-1].psum_q;
  assign carry     = g_stg[NSTAGES-1].c_q;

`ifdef PIPELINED_ADDER_SIGNED_OVF_EN
  logic ovf_d, ovf_q;

  // Carry into the MSB is recovered as a ^ b ^ s at that bit.
  always_comb begin
    ovf_d = ovf_q;
    if (g_stg[NSTAGES-1].ld)
      ovf_d = g_stg[NSTAGES-1].ca[STAGE_W-1] ^ g_stg[NSTAGES-1].cb[STAGE_W-1]
            ^ g_stg[NSTAGES-1].cs[STAGE_W-1] ^ g_stg[NSTAGES-1].co;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_parallel_adder.sv
// Scoreboard bench: an 8-bit (2-stage) instance for directed cases and a 16-bit (4-stage) one for random traffic.
module tb_pipelined_parallel_adder;
  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          acc;
    int          stl;
  } exp_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (inst %0d) got %0h expected %0h", nm, g, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int W = (g == 0) ? 8 : 16;
    localparam int N = W / 4;

    logic         rst_n = 1'b1, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, carry;
    logic [W-1:0] a = '0, b = '0, sum;
`ifdef PIPELINED_ADDER_SIGNED_OVF_EN
    logic         ovf;
`endif
    logic         done_f = 1'b0;
    logic         held_v = 1'b0, held_c = 1'b0;
    logic [W-1:0] held_s = '0;
    int           cyc = 0, stalls = 0;
    exp_t         q[$];

    pipelined_parallel_adder #(.WIDTH(W), .STAGE_W(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry     (carry)
`ifdef PIPELINED_ADDER_SIGNED_OVF_EN
      ,
      .ovf       (ovf)
`endif
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on the unsigned and signed views of the operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
      exp_t   e;
      longint ux, uy, r, sx, sy, sr, lim, cl;
      lim = longint'(1) << W;
      ux  = longint'(x);
      uy  = longint'(y);
      cl  = ci ? 1 : 0;
      r   = sb ? ux - uy - cl : ux + uy + cl;
      e.s = 16'(r & (lim - 1));
      e.c = sb ? (ux >= uy + cl) : (r >= lim);
      sx  = (ux >= lim / 2) ? ux - lim : ux;
      sy  = (uy >= lim / 2) ? uy - lim : uy;
      sr  = sb ? sx - sy - cl : sx + sy + cl;
      e.o = (sr >= lim / 2) || (sr < -(lim / 2));
      e.acc = cyc;
      e.stl = stalls;
      return e;
    endfunction

    always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
        held_v <= 1'b0;
      end else begin
        if (held_v) begin
          chk("stall_valid", g, out_valid, 1);
          chk("stall_sum",   g, sum,       held_s);
          chk("stall_carry", g, carry,     held_c);
        end
        held_v <= out_valid && !out_ready;
        held_s <= sum;
        held_c <= carry;
        if (out_valid && !out_ready) begin
          stalls <= stalls + 1;
          chk("stall_in_ready", g, in_ready, 0);
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("spurious_out", g, out_valid, 0);
          else begin
            e = q.pop_front();
            chk("sum",   g, sum,   e.s[W-1:0]);
            chk("carry", g, carry, e.c);
`ifdef PIPELINED_ADDER_SIGNED_OVF_EN
            chk("ovf",   g, ovf,   e.o);
`endif
            if (e.stl == stalls) chk("latency", g, cyc - e.acc, N);
          end
        end
      end
    end

    task automatic op(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic ci, input logic sb, input logic rdy);
      in_valid = v; a = x; b = y; cin = ci; sub = sb; out_ready = rdy;
      @(negedge clk);
      if (in_valid && in_ready) q.push_back(model(x, y, ci, sb));
      @(posedge clk);
      #1;
    endtask

    task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 60) begin
        op(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        n++;
      end
      chk("drain_empty", g, q.size(), 0);
    endtask

    task automatic do_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      chk("rst_out_valid", g, out_valid, 0);
      chk("rst_sum",       g, sum,       0);
      chk("rst_carry",     g, carry,     0);
      chk("rst_in_ready",  g, in_ready,  1);
      q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
    endtask

    task automatic rand_ops(input int nops);
      for (int i = 0; i < nops; i++)
        op($urandom_range(0, 9) < 8, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 7);
      drain();
    endtask

    if (g == 0) begin : g_dir
      initial begin
        #2;
        do_reset();
        // add wrap-around, then subtract with and without borrow
        op(1, 8'hFF, 8'h01, 0, 0, 1);
        drain();
        op(1, 8'h10, 8'h01, 0, 1, 1);
        op(1, 8'h00, 8'h01, 0, 1, 1);
        drain();
        // back-to-back with mode changes
        op(1, 8'd3,   8'd4, 0, 0, 1);
        op(1, 8'd9,   8'd2, 0, 1, 1);
        op(1, 8'd255, 8'd1, 1, 0, 1);
        op(1, 8'd0,   8'd0, 1, 1, 1);
        drain();
        // fill, then backpressure for three cycles with new ops offered
        op(1, 8'h21, 8'h43, 0, 0, 1);
        op(1, 8'h80, 8'h7F, 1, 1, 1);
        op(1, 8'h11, 8'h11, 0, 0, 0);
        op(1, 8'h22, 8'h22, 0, 0, 0);
        op(1, 8'h33, 8'h33, 0, 0, 0);
        drain();
        // reset with two operations in flight
        op(1, 8'hAA, 8'h01, 0, 0, 1);
        op(1, 8'hBB, 8'h01, 0, 0, 1);
        do_reset();
        op(0, 8'h00, 8'h00, 0, 0, 1);
        op(0, 8'h00, 8'h00, 0, 0, 1);
        op(1, 8'd5, 8'd5, 0, 0, 1);
        drain();
        // signed overflow corners
        op(1, 8'h7F, 8'h01, 0, 0, 1);
        op(1, 8'h80, 8'h01, 0, 1, 1);
        op(1, 8'h01, 8'h01, 0, 0, 1);
        drain();
        rand_ops(2000);
        done_f = 1'b1;
      end
    end else begin : g_rnd
      initial begin
        #2;
        do_reset();
        rand_ops(10000);
        done_f = 1'b1;
      end
    end
  end

  initial begin
    wait (g_cfg[0].done_f && g_cfg[1].done_f);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
